// File: rtl/serial_tx_arbiter_if.sv
// Request/grant/done bundle between the ADC channel sequencers and the shared
// serial transmitter, plus the serial line and status outputs.
interface serial_tx_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]   req;
    logic [8*NUM_CH-1:0] data_in;
    logic                dsr;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   done;
    logic                busy;
    logic [CH_W-1:0]     cur_ch;
    logic                data_out;
    logic                error;

    modport master (
        output req, data_in, dsr,
        input  grant, done, busy, cur_ch, data_out, error
    );

    modport slave (
        input  req, data_in, dsr,
        output grant, done, busy, cur_ch, data_out, error
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one start/8-bit-MSB-first/stop serial
// transmitter between NUM_CH byte producers.
module serial_tx_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int BIT_CYCLES = 105
) (
    input  logic              clock,
    input  logic              reset_n,
    serial_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [3:0]        SLOT_START = 4'd0;
    localparam logic [3:0]        SLOT_B0    = 4'd8;
    localparam logic [3:0]        SLOT_STOP  = 4'd9;
    localparam logic [NUM_CH-1:0] ONE_HOT0   = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [7:0]          shift_q, shift_d;
    logic [3:0]          slot_q, slot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic                busy_q, busy_d;
    logic                data_out_q, data_out_d;
    logic                error_q, error_d;

    logic                win_found_s;
    logic [CH_W-1:0]     win_s;
    logic [7:0]          win_byte_s;
    logic [CH_W-1:0]     ptr_next_s;

    // Round-robin winner: first set request at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        win_found_s = |bus.req;
        win_s       = '0;
        win_byte_s  = 8'h00;
        // Walk the rotation backwards so the earliest requester is written last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx        = (int'(ptr_q) + i) % NUM_CH;
            win_s      = bus.req[idx] ? CH_W'(idx) : win_s;
            win_byte_s = bus.req[idx] ? bus.data_in[8*idx +: 8] : win_byte_s;
        end
    end

    // Pointer value after the current frame: the channel just served moves last.
    always_comb begin
        if (cur_ch_q == LAST_CH) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = cur_ch_q + CH_W'(1);
        end
    end

    // Next-state and output logic for the IDLE/XMIT frame sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_ch_d   = cur_ch_q;
        shift_d    = shift_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        grant_d    = '0;
        done_d     = '0;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                data_out_d = 1'b1;
                if (win_found_s && bus.dsr) begin
                    state_d    = XMIT;
                    cur_ch_d   = win_s;
                    shift_d    = win_byte_s;
                    slot_d     = SLOT_START;
                    cnt_d      = '0;
                    grant_d    = ONE_HOT0 << win_s;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    data_out_d = 1'b0;
                end else if (win_found_s) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
            end

            XMIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (slot_q == SLOT_STOP) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        done_d     = ONE_HOT0 << cur_ch_q;
                        ptr_d      = ptr_next_s;
                        data_out_d = 1'b1;
                    end else if (slot_q == SLOT_B0) begin
                        slot_d     = SLOT_STOP;
                        data_out_d = 1'b1;
                    end else begin
                        // Entering a data slot: present the MSB, then shift it out.
                        slot_d     = slot_q + 4'd1;
                        data_out_d = shift_q[7];
                        shift_d    = {shift_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                data_out_d = 1'b1;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cur_ch_q   <= '0;
            shift_q    <= 8'h00;
            slot_q     <= 4'd0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            data_out_q <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_ch_q   <= cur_ch_d;
            shift_q    <= shift_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.cur_ch   = cur_ch_q;
    assign bus.data_out = data_out_q;
    assign bus.error    = error_q;
endmodule
